// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: PCSrc encodings, fetch FSM states, NOP.
// Imported by pc_next_sel and fetch_stage.
package fetch_pkg;

    localparam logic [2:0]  PCSRC_BRANCH = 3'd1;
    localparam logic [2:0]  PCSRC_JUMP   = 3'd2;
    localparam logic [2:0]  PCSRC_JR     = 3'd3;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect priority mux: a taken EX branch beats an ID jump/jr.
// Targets are word-aligned by clearing bits [1:0].
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [2:0]  i_EX_PCSrc,
    input  logic        i_EX_ALUOut_0,
    input  logic [2:0]  i_ID_PCSrc,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic [31:0] i_jr_target,
    output logic        o_redirect,
    output logic [31:0] o_redirect_target
);

    always_comb begin
        o_redirect        = 1'b0;
        o_redirect_target = '0;
        if (i_EX_PCSrc == PCSRC_BRANCH && i_EX_ALUOut_0) begin
            o_redirect        = 1'b1;
            o_redirect_target = i_branch_target & ~32'h3;
        end else if (i_ID_PCSrc == PCSRC_JUMP) begin
            o_redirect        = 1'b1;
            o_redirect_target = i_jump_target & ~32'h3;
        end else if (i_ID_PCSrc == PCSRC_JR) begin
            o_redirect        = 1'b1;
            o_redirect_target = i_jr_target & ~32'h3;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, one-entry buffer and IF/ID register.
// Optional perf counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_PCWrite,
    input  logic        i_IF_ID_write,
    input  logic        i_IF_ID_flush,
    input  logic [2:0]  i_ID_PCSrc,
    input  logic [2:0]  i_EX_PCSrc,
    input  logic        i_EX_ALUOut_0,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic [31:0] i_jr_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_IF_ID_instr,
    output logic [31:0] o_IF_ID_PC_plus_4,
    output logic        o_IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_bubble_cnt,
    output logic [31:0] o_perf_drop_cnt
`endif
);

    fetch_state_e r_state;
    fetch_state_e w_nextState;
    logic [31:0]  r_pc, w_nextPc, w_pcPlus4;
    logic [31:0]  r_fbuf;
    logic         r_fbufValid;
    logic [31:0]  r_ifIdInstr, r_ifIdPcPlus4;
    logic         r_ifIdValid;
    logic         w_redirect, w_redirTake;
    logic [31:0]  w_redirectTarget;
    logic         w_rspInWait, w_avail, w_consume;
    logic         w_req, w_fbufLoad;
    logic [31:0]  w_reqAddr;

    pc_next_sel u_pcNextSel (
        .i_EX_PCSrc        (i_EX_PCSrc),
        .i_EX_ALUOut_0     (i_EX_ALUOut_0),
        .i_ID_PCSrc        (i_ID_PCSrc),
        .i_branch_target   (i_branch_target),
        .i_jump_target     (i_jump_target),
        .i_jr_target       (i_jr_target),
        .o_redirect        (w_redirect),
        .o_redirect_target (w_redirectTarget)
    );

    // A redirect wins over consumption: the instruction in hand is on the wrong path.
    always_comb begin
        w_pcPlus4   = r_pc + 32'd4;
        w_redirTake = w_redirect & i_PCWrite;
        w_rspInWait = (r_state == ST_WAIT) & i_imem_rvalid;
        w_avail     = r_fbufValid | w_rspInWait;
        w_consume   = i_IF_ID_write & ~i_IF_ID_flush & i_PCWrite & w_avail & ~w_redirTake;
    end

    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_req       = 1'b0;
        w_reqAddr   = r_pc;
        w_fbufLoad  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_req = 1'b1;
                if (w_redirTake) begin
                    w_nextPc    = w_redirectTarget;
                    w_nextState = i_imem_ready ? ST_DROP : ST_FETCH;
                end else if (i_imem_ready) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_redirTake) begin
                    w_nextPc    = w_redirectTarget;
                    w_nextState = i_imem_rvalid ? ST_FETCH : ST_DROP;
                end else if (i_imem_rvalid) begin
                    // Bypass cycle also issues the next request, giving one fetch per cycle.
                    if (w_consume) begin
                        w_req       = 1'b1;
                        w_reqAddr   = w_pcPlus4;
                        w_nextPc    = w_pcPlus4;
                        w_nextState = i_imem_ready ? ST_WAIT : ST_FETCH;
                    end else begin
                        w_fbufLoad  = 1'b1;
                        w_nextState = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_redirTake) begin
                    w_nextPc    = w_redirectTarget;
                    w_nextState = ST_FETCH;
                end else if (w_consume) begin
                    w_nextPc    = w_pcPlus4;
                    w_nextState = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (w_redirTake) begin
                    w_nextPc = w_redirectTarget;
                end
                if (i_imem_rvalid) begin
                    w_nextState = ST_FETCH;
                end
            end
            default: w_nextState = ST_FETCH;
        endcase
    end

    assign o_imem_req  = w_req & i_reset_n;
    assign o_imem_addr = w_reqAddr;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_fbuf      <= NOP_INSTR;
            r_fbufValid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            if (w_fbufLoad) begin
                r_fbuf <= i_imem_rdata;
            end
            if (w_redirTake) begin
                r_fbufValid <= 1'b0;
            end else if (w_fbufLoad) begin
                r_fbufValid <= 1'b1;
            end else if (w_consume) begin
                r_fbufValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ifIdInstr   <= NOP_INSTR;
            r_ifIdPcPlus4 <= '0;
            r_ifIdValid   <= 1'b0;
        end else if (i_IF_ID_flush) begin
            r_ifIdInstr <= NOP_INSTR;
            r_ifIdValid <= 1'b0;
        end else if (i_IF_ID_write) begin
            if (w_consume) begin
                r_ifIdInstr   <= r_fbufValid ? r_fbuf : i_imem_rdata;
                r_ifIdPcPlus4 <= w_pcPlus4;
                r_ifIdValid   <= 1'b1;
            end else begin
                r_ifIdInstr <= NOP_INSTR;
                r_ifIdValid <= 1'b0;
            end
        end
    end

    assign o_IF_ID_instr     = r_ifIdInstr;
    assign o_IF_ID_PC_plus_4 = r_ifIdPcPlus4;
    assign o_IF_ID_valid     = r_ifIdValid;

`ifdef FETCH_PERF_CNT_EN
    logic        w_bubble, w_drop;
    logic [31:0] r_perfBubbleCnt, r_perfDropCnt;

    always_comb begin
        w_bubble = i_IF_ID_write & ~i_IF_ID_flush & ~w_consume;
        w_drop   = ((r_state == ST_DROP) & i_imem_rvalid) | (w_rspInWait & w_redirTake);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_perfBubbleCnt <= '0;
            r_perfDropCnt   <= '0;
        end else begin
            r_perfBubbleCnt <= r_perfBubbleCnt + {31'b0, w_bubble};
            r_perfDropCnt   <= r_perfDropCnt + {31'b0, w_drop};
        end
    end

    assign o_perf_bubble_cnt = r_perfBubbleCnt;
    assign o_perf_drop_cnt   = r_perfDropCnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small in-order instruction memory responder.
// Perf-counter checks are compiled only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetN;
    logic        pcWrite, ifIdWrite, ifIdFlush;
    logic [2:0]  idPcSrc, exPcSrc;
    logic        exAluOut0;
    logic [31:0] branchTarget, jumpTarget, jrTarget;
    logic        imemReq, imemReady, imemRvalid;
    logic [31:0] imemAddr, imemRdata;
    logic [31:0] ifIdInstr, ifIdPcPlus4;
    logic        ifIdValid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfBubbleCnt, perfDropCnt;
    logic [31:0] bubbleBase;
`endif

    int          nChecks = 0;
    int          nFails  = 0;
    int          latency = 1;
    bit          pendValid = 1'b0;
    logic [31:0] pendAddr = '0;
    int          pendWait = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk             (clk),
        .i_reset_n         (resetN),
        .i_PCWrite         (pcWrite),
        .i_IF_ID_write     (ifIdWrite),
        .i_IF_ID_flush     (ifIdFlush),
        .i_ID_PCSrc        (idPcSrc),
        .i_EX_PCSrc        (exPcSrc),
        .i_EX_ALUOut_0     (exAluOut0),
        .i_branch_target   (branchTarget),
        .i_jump_target     (jumpTarget),
        .i_jr_target       (jrTarget),
        .o_imem_req        (imemReq),
        .o_imem_addr       (imemAddr),
        .i_imem_ready      (imemReady),
        .i_imem_rvalid     (imemRvalid),
        .i_imem_rdata      (imemRdata),
        .o_IF_ID_instr     (ifIdInstr),
        .o_IF_ID_PC_plus_4 (ifIdPcPlus4),
        .o_IF_ID_valid     (ifIdValid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_bubble_cnt (perfBubbleCnt),
        .o_perf_drop_cnt   (perfDropCnt)
`endif
    );

    // Instruction word stored at an address
    function automatic logic [31:0] memData(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkIfId(input string tag, input logic valid, input logic [31:0] instr, input logic [31:0] pc4);
        checkOutput({tag, ".valid"}, {31'b0, ifIdValid}, {31'b0, valid});
        checkOutput({tag, ".instr"}, ifIdInstr, instr);
        if (valid) checkOutput({tag, ".pc4"}, ifIdPcPlus4, pc4);
    endtask

    task automatic checkReq(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, ".req"}, {31'b0, imemReq}, {31'b0, req});
        if (req) checkOutput({tag, ".addr"}, imemAddr, addr);
    endtask

    // One clock: sample the handshake, let the edge pass, then advance the memory responder.
    task automatic applyStimulus(input int n);
        logic        acc;
        logic [31:0] accAddr;
        for (int c = 0; c < n; c++) begin
            #1;
            acc     = imemReq & imemReady;
            accAddr = imemAddr;
            @(posedge clk);
            #1;
            if (imemRvalid) pendValid = 1'b0;
            else if (pendValid && pendWait > 0) pendWait--;
            if (acc) begin
                pendValid = 1'b1;
                pendAddr  = accAddr;
                pendWait  = latency - 1;
            end
            imemRvalid = pendValid && (pendWait == 0);
            imemRdata  = imemRvalid ? memData(pendAddr) : 32'hDEAD_BEEF;
            @(negedge clk);
        end
    endtask

    initial begin
        resetN = 1'b0; pcWrite = 1'b1; ifIdWrite = 1'b1; ifIdFlush = 1'b0;
        idPcSrc = 3'd0; exPcSrc = 3'd0; exAluOut0 = 1'b0;
        branchTarget = '0; jumpTarget = '0; jrTarget = '0;
        imemReady = 1'b1; imemRvalid = 1'b0; imemRdata = 32'hDEAD_BEEF;

        // Reset values
        #12;
        checkReq("reset", 1'b0, 32'h0);
        checkIfId("reset", 1'b0, 32'h0, 32'h0);
        checkOutput("reset.pc4", ifIdPcPlus4, 32'h0);
        @(negedge clk); @(negedge clk);
        resetN = 1'b1;
        #1;
        checkReq("first_req", 1'b1, 32'h0);

        // Zero-wait streaming
        applyStimulus(1);
        checkReq("stream1", 1'b1, 32'h4);
        checkIfId("stream1", 1'b0, 32'h0, 32'h0);
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(1);
            checkReq("stream", 1'b1, 32'(4 * k));
            checkIfId("stream", 1'b1, 32'hC0DE_0000 | 32'(4 * (k - 2)), 32'(4 * (k - 1)));
        end

        // Load-use stall while the response for 0x1C arrives
        pcWrite = 1'b0; ifIdWrite = 1'b0;
        #1;
        checkReq("stall0", 1'b0, 32'h0);
        applyStimulus(1);
        checkReq("stall1", 1'b0, 32'h0);
        checkIfId("stall1", 1'b1, 32'hC0DE_0018, 32'h1C);
        applyStimulus(1);
        checkIfId("stall2", 1'b1, 32'hC0DE_0018, 32'h1C);
        pcWrite = 1'b1; ifIdWrite = 1'b1;
        applyStimulus(1);
        checkIfId("unstall1", 1'b1, 32'hC0DE_001C, 32'h20);
        checkReq("unstall1", 1'b1, 32'h20);
        applyStimulus(1);
        checkIfId("unstall2", 1'b0, 32'h0, 32'h0);
        checkReq("unstall2", 1'b1, 32'h24);
        applyStimulus(1);
        checkIfId("unstall3", 1'b1, 32'hC0DE_0020, 32'h24);

        // Memory not ready for 4 cycles
        imemReady = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        #1 bubbleBase = perfBubbleCnt;
`endif
        applyStimulus(1);
        checkReq("notready1", 1'b1, 32'h28);
        checkIfId("notready1", 1'b1, 32'hC0DE_0024, 32'h28);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(1);
            checkReq("notready", 1'b1, 32'h28);
            checkIfId("notready", 1'b0, 32'h0, 32'h0);
        end
        imemReady = 1'b1;
        applyStimulus(1);
        checkIfId("ready5", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("bubble_cnt", perfBubbleCnt - bubbleBase, 32'd4);
`endif
        applyStimulus(1);
        checkIfId("ready6", 1'b1, 32'hC0DE_0028, 32'h2C);

        // Taken branch to 0x100 with a 3-cycle response outstanding
        latency = 3;
        applyStimulus(1);
        checkReq("lat3_wait", 1'b0, 32'h0);
        checkIfId("lat3_wait", 1'b1, 32'hC0DE_002C, 32'h30);
        applyStimulus(1);
        exPcSrc = 3'd1; exAluOut0 = 1'b1; branchTarget = 32'h100;
        applyStimulus(1);
        exPcSrc = 3'd0; exAluOut0 = 1'b0;
        checkReq("branch_drop", 1'b0, 32'h0);
        checkIfId("branch_drop", 1'b0, 32'h0, 32'h0);
        applyStimulus(1);
        checkReq("branch_target", 1'b1, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("drop_cnt1", perfDropCnt, 32'd1);
`endif
        applyStimulus(2);
        latency = 1;
        applyStimulus(1);
        checkReq("branch_bypass", 1'b1, 32'h104);
        applyStimulus(1);
        checkIfId("branch_instr", 1'b1, 32'hC0DE_0100, 32'h104);

        // Branch and jump together: branch wins
        exPcSrc = 3'd1; exAluOut0 = 1'b1; branchTarget = 32'h200;
        idPcSrc = 3'd2; jumpTarget = 32'h300;
        #1;
        checkReq("br_jmp_same", 1'b0, 32'h0);
        applyStimulus(1);
        exPcSrc = 3'd0; exAluOut0 = 1'b0; idPcSrc = 3'd0;
        checkReq("br_jmp_next", 1'b1, 32'h200);
        checkIfId("br_jmp_next", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("drop_cnt2", perfDropCnt, 32'd2);
`endif

        // jr from FETCH with an unaligned target; the accepted request is stale
        idPcSrc = 3'd3; jrTarget = 32'h403;
        applyStimulus(1);
        idPcSrc = 3'd0;
        checkReq("jr_drop", 1'b0, 32'h0);
        applyStimulus(1);
        checkReq("jr_target", 1'b1, 32'h400);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("drop_cnt3", perfDropCnt, 32'd3);
`endif

        // Flush bubbles IF/ID but keeps the buffered instruction
        applyStimulus(1);
        ifIdFlush = 1'b1;
        #1;
        checkReq("flush_noreq", 1'b0, 32'h0);
        applyStimulus(1);
        ifIdFlush = 1'b0;
        checkIfId("flush_bubble", 1'b0, 32'h0, 32'h0);
        applyStimulus(1);
        checkIfId("flush_keep", 1'b1, 32'hC0DE_0400, 32'h404);
        checkReq("flush_keep", 1'b1, 32'h404);

        // Reset pulse while a 3-cycle response is outstanding
        latency = 3;
        applyStimulus(1);
        checkReq("pre_reset_wait", 1'b0, 32'h0);
        resetN = 1'b0;
        #1;
        checkReq("midreset", 1'b0, 32'h0);
        checkIfId("midreset", 1'b0, 32'h0, 32'h0);
        checkOutput("midreset.pc4", ifIdPcPlus4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("midreset.bubble_cnt", perfBubbleCnt, 32'd0);
        checkOutput("midreset.drop_cnt", perfDropCnt, 32'd0);
`endif
        applyStimulus(1);
        imemReady = 1'b0;
        resetN = 1'b1;
        #1;
        checkReq("restart", 1'b1, 32'h0);
        applyStimulus(1);
        checkReq("stale_rsp", 1'b1, 32'h0);
        checkIfId("stale_rsp", 1'b0, 32'h0, 32'h0);
        applyStimulus(1);
        checkReq("stale_ignored", 1'b1, 32'h0);
        checkIfId("stale_ignored", 1'b0, 32'h0, 32'h0);
        latency = 1;
        imemReady = 1'b1;
        applyStimulus(1);
        checkIfId("restart_wait", 1'b0, 32'h0, 32'h0);
        applyStimulus(1);
        checkIfId("restart_instr", 1'b1, 32'hC0DE_0000, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
